// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin arbiter sharing one SPI master between CLIENTS ports.
// Each client uses a toggle req/ack handshake. A client holding cli_lock keeps the bus
// between bytes.
// Optional feature: define SPI_ARB_TIMEOUT_EN to force release of a lock that has sat
// idle for TIMEOUT_CYCLES.
module spi_arbiter #(
    parameter int unsigned CLIENTS        = 2,
    parameter int unsigned CLIENT_BITS    = 1,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [CLIENTS-1:0]     cli_req,
    output logic [CLIENTS-1:0]     cli_ack,
    input  logic [8*CLIENTS-1:0]   cli_d,
    input  logic [CLIENTS-1:0]     cli_speed,
    input  logic [CLIENTS-1:0]     cli_lock,
    output logic [7:0]             cli_q,
    output logic                   spi_req,
    input  logic                   spi_ack,
    output logic [7:0]             spi_d,
    output logic                   spi_speed,
    input  logic [7:0]             spi_q,
    output logic [CLIENT_BITS-1:0] owner,
    output logic                   owner_valid,
    output logic                   timeout
);

    localparam int unsigned IdxW = (CLIENTS > 1) ? $clog2(CLIENTS) : 1;

    typedef enum logic [1:0] {StResync, StIdle, StIssue, StWait} state_e;

    state_e             state_q, state_d;
    logic [IdxW-1:0]    owner_q, owner_d;
    logic               owner_valid_q, owner_valid_d;
    logic [CLIENTS-1:0] cli_ack_q, cli_ack_d;
    logic               spi_req_q, spi_req_d;
    logic [7:0]         spi_d_q, spi_d_d;
    logic               spi_speed_q, spi_speed_d;
    logic [7:0]         cli_q_q, cli_q_d;

    logic [CLIENTS-1:0] pending;
    logic [CLIENTS-1:0] lock_eff;
    logic               locked;
    logic               found;
    logic [IdxW-1:0]    grant_idx;
    logic [7:0]         cli_byte [CLIENTS];

`ifdef SPI_ARB_TIMEOUT_EN
    logic               timeout_q, timeout_d;
    logic [CLIENTS-1:0] mask_q, mask_d;
    logic [31:0]        cnt_q, cnt_d;

    // A lock broken by timeout stays ignored until the client lets go of it.
    assign lock_eff = cli_lock & ~mask_q;
    assign timeout  = timeout_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign lock_eff = cli_lock;
    assign timeout  = 1'b0;
`endif

    assign pending = cli_req ^ cli_ack_q;
    assign locked  = owner_valid_q & lock_eff[owner_q];

    // Split the flat client data bus into per-client bytes.
    always_comb begin
        for (int unsigned i = 0; i < CLIENTS; i++) begin
            cli_byte[i] = cli_d[8*i +: 8];
        end
    end

    // Round-robin scan: first pending client after the current owner, wrapping round.
    always_comb begin
        logic [31:0] cand;
        cand      = '0;
        found     = 1'b0;
        grant_idx = owner_q;
        for (int unsigned i = 1; i <= CLIENTS; i++) begin
            cand = (32'(owner_q) + i) % CLIENTS;
            if (!found && pending[cand[IdxW-1:0]]) begin
                found     = 1'b1;
                grant_idx = cand[IdxW-1:0];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StResync;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StResync: state_d = StIdle;
            StIdle: begin
                if (locked ? pending[owner_q] : found) begin
                    state_d = StIssue;
                end
            end
            StIssue:  state_d = StWait;
            StWait: begin
                if (spi_ack == spi_req_q) begin
                    state_d = StIdle;
                end
            end
            default:  state_d = StResync;
        endcase
    end

    // Output and datapath next values.
    always_comb begin
        owner_d       = owner_q;
        owner_valid_d = owner_valid_q;
        cli_ack_d     = cli_ack_q;
        spi_req_d     = spi_req_q;
        spi_d_d       = spi_d_q;
        spi_speed_d   = spi_speed_q;
        cli_q_d       = cli_q_q;
`ifdef SPI_ARB_TIMEOUT_EN
        timeout_d     = 1'b0;
        mask_d        = mask_q & cli_lock;
        cnt_d         = '0;
`endif
        unique case (state_q)
            // Discard any mismatch left over from a reset taken mid-transfer.
            StResync: spi_req_d = spi_ack;
            StIdle: begin
                if (locked) begin
                    if (pending[owner_q]) begin
                        spi_d_d     = cli_byte[owner_q];
                        spi_speed_d = cli_speed[owner_q];
                    end
`ifdef SPI_ARB_TIMEOUT_EN
                    else if (cnt_q == TIMEOUT_CYCLES - 1) begin
                        timeout_d      = 1'b1;
                        owner_valid_d  = 1'b0;
                        mask_d[owner_q] = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
`endif
                end else if (found) begin
                    owner_d       = grant_idx;
                    owner_valid_d = 1'b1;
                    spi_d_d       = cli_byte[grant_idx];
                    spi_speed_d   = cli_speed[grant_idx];
                end else begin
                    // owner stays as the round-robin pointer.
                    owner_valid_d = 1'b0;
                end
            end
            StIssue:  spi_req_d = ~spi_req_q;
            StWait: begin
                if (spi_ack == spi_req_q) begin
                    cli_q_d            = spi_q;
                    cli_ack_d[owner_q] = ~cli_ack_q[owner_q];
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q       <= IdxW'(CLIENTS - 1);
            owner_valid_q <= 1'b0;
            cli_ack_q     <= '0;
            spi_req_q     <= 1'b0;
            spi_d_q       <= '0;
            spi_speed_q   <= 1'b0;
            cli_q_q       <= '0;
        end else begin
            owner_q       <= owner_d;
            owner_valid_q <= owner_valid_d;
            cli_ack_q     <= cli_ack_d;
            spi_req_q     <= spi_req_d;
            spi_d_q       <= spi_d_d;
            spi_speed_q   <= spi_speed_d;
            cli_q_q       <= cli_q_d;
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    // Lock-timeout registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_q <= 1'b0;
            mask_q    <= '0;
            cnt_q     <= '0;
        end else begin
            timeout_q <= timeout_d;
            mask_q    <= mask_d;
            cnt_q     <= cnt_d;
        end
    end
`endif

    // Zero-extend the internal owner index onto the owner port.
    always_comb begin
        owner             = '0;
        owner[IdxW-1:0]   = owner_q;
    end

    assign cli_ack     = cli_ack_q;
    assign spi_req     = spi_req_q;
    assign spi_d       = spi_d_q;
    assign spi_speed   = spi_speed_q;
    assign cli_q       = cli_q_q;
    assign owner_valid = owner_valid_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Testbench for spi_arbiter with three clients. Expected transfers are pushed to a
// scoreboard when a client raises a request and matched when the arbiter issues to SPI.
module tb_spi_arbiter;

    localparam int unsigned N = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   cli_req;
    logic [N-1:0]   cli_ack;
    logic [8*N-1:0] cli_d;
    logic [N-1:0]   cli_speed;
    logic [N-1:0]   cli_lock;
    logic [7:0]     cli_q;
    logic           spi_req;
    logic           spi_ack;
    logic [7:0]     spi_d;
    logic           spi_speed;
    logic [7:0]     spi_q;
    logic [1:0]     owner;
    logic           owner_valid;
    logic           timeout;

    typedef struct packed {
        logic [1:0] cli;
        logic [7:0] d;
        logic       spd;
    } xfer_t;

    xfer_t        sb[$];
    logic [N-1:0] exp_ack;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    spi_arbiter #(
        .CLIENTS       (N),
        .CLIENT_BITS   (2),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cli_req    (cli_req),
        .cli_ack    (cli_ack),
        .cli_d      (cli_d),
        .cli_speed  (cli_speed),
        .cli_lock   (cli_lock),
        .cli_q      (cli_q),
        .spi_req    (spi_req),
        .spi_ack    (spi_ack),
        .spi_d      (spi_d),
        .spi_speed  (spi_speed),
        .spi_q      (spi_q),
        .owner      (owner),
        .owner_valid(owner_valid),
        .timeout    (timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic toggle_req(input int c, input logic [7:0] d, input logic spd);
        xfer_t x;
        cli_d[8*c +: 8] = d;
        cli_speed[c]    = spd;
        cli_req[c]      = ~cli_req[c];
        x.cli = 2'(c);
        x.d   = d;
        x.spd = spd;
        sb.push_back(x);
    endtask

    task automatic wait_issue();
        int n = 0;
        while (spi_req === spi_ack && n < 64) begin
            tick(1);
            n++;
        end
        check("issue_seen", {31'b0, spi_req ^ spi_ack}, 1);
    endtask

    task automatic grant_check(input int exp_owner);
        int idx = -1;
        check("owner", owner, exp_owner);
        check("owner_valid", owner_valid, 1);
        foreach (sb[i]) begin
            if (idx < 0 && int'(sb[i].cli) == exp_owner) idx = i;
        end
        if (idx < 0) begin
            $display("FAIL sb_lookup: no expected entry for client %0d", exp_owner);
            $fatal(1, "scoreboard empty");
        end
        check("spi_d", spi_d, sb[idx].d);
        check("spi_speed", spi_speed, sb[idx].spd);
        sb.delete(idx);
    endtask

    task automatic complete(input int c, input logic [7:0] rsp);
        spi_q   = rsp;
        spi_ack = spi_req;
        tick(1);
        exp_ack[c] = ~exp_ack[c];
        check("cli_q", cli_q, rsp);
        check("cli_ack", cli_ack, exp_ack);
    endtask

    task automatic serve(input int c, input logic [7:0] rsp);
        wait_issue();
        grant_check(c);
        complete(c, rsp);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int to_seen;
        int issued;
        reset     = 1'b1;
        cli_req   = '0;
        cli_d     = '0;
        cli_speed = '0;
        cli_lock  = '0;
        spi_ack   = 1'b0;
        spi_q     = '0;
        exp_ack   = '0;
        tick(3);

        // Reset values.
        check("rst_cli_ack", cli_ack, 0);
        check("rst_spi_req", spi_req, 0);
        check("rst_spi_d", spi_d, 0);
        check("rst_spi_speed", spi_speed, 0);
        check("rst_cli_q", cli_q, 0);
        check("rst_owner", owner, N - 1);
        check("rst_owner_valid", owner_valid, 0);
        check("rst_timeout", timeout, 0);
        reset = 1'b0;
        tick(1);

        // Single transfer and issue latency.
        toggle_req(0, 8'hA5, 1'b1);
        tick(1);
        check("lat_early", spi_req, 0);
        tick(1);
        check("lat_toggle", spi_req, 1);
        serve(0, 8'h3C);

        // Move the pointer to client 2, then all three at once: 0,1,2, then wrap to 0.
        toggle_req(2, 8'h5A, 1'b0);
        serve(2, 8'h11);
        toggle_req(0, 8'h10, 1'b1);
        toggle_req(1, 8'h21, 1'b0);
        toggle_req(2, 8'h32, 1'b1);
        serve(0, 8'hC0);
        serve(1, 8'hC1);
        serve(2, 8'hC2);
        toggle_req(0, 8'h44, 1'b0);
        serve(0, 8'hC3);
        tick(2);
        check("idle_owner_valid", owner_valid, 0);
        check("idle_owner_kept", owner, 0);

        // Client 1 locks across 4 bytes while client 0 waits.
        cli_lock[1] = 1'b1;
        toggle_req(1, 8'h80, 1'b1);
        serve(1, 8'hD0);
        toggle_req(0, 8'h0F, 1'b0);
        for (int k = 1; k < 4; k++) begin
            tick(3);
            check("lock_hold", {31'b0, spi_req ^ spi_ack}, 0);
            check("lock_owner", owner, 1);
            toggle_req(1, 8'(8'h80 + k), k[0]);
            serve(1, 8'(8'hD0 + k));
        end
        tick(5);
        check("lock_hold_end", {31'b0, spi_req ^ spi_ack}, 0);
        check("lock_owner_valid", owner_valid, 1);
        cli_lock[1] = 1'b0;
        serve(0, 8'hE0);

        // Reset while waiting for the SPI master with req != ack.
        toggle_req(2, 8'h99, 1'b1);
        wait_issue();
        grant_check(2);
        #2;
        reset   = 1'b1;
        cli_req = '0;
        spi_ack = 1'b1;
        #1;
        check("rst_async_spi_req", spi_req, 0);
        check("rst_async_cli_ack", cli_ack, 0);
        check("rst_async_owner", owner, N - 1);
        check("rst_async_owner_valid", owner_valid, 0);
        check("rst_async_cli_q", cli_q, 0);
        exp_ack = '0;
        tick(2);
        reset = 1'b0;
        tick(1);
        check("resync_req", spi_req, 1);
        tick(3);
        check("no_spurious_ack", cli_ack, 0);
        check("resync_idle", {31'b0, spi_req ^ spi_ack}, 0);
        toggle_req(0, 8'h66, 1'b0);
        serve(0, 8'h77);

        // Client 0 locked and idle while client 1 is pending.
        cli_lock[0] = 1'b1;
        toggle_req(0, 8'h12, 1'b1);
        serve(0, 8'h34);
        toggle_req(1, 8'h56, 1'b0);
`ifdef SPI_ARB_TIMEOUT_EN
        n = 0;
        while (timeout !== 1'b1 && n < 64) begin
            tick(1);
            n++;
        end
        check("timeout_pulse", timeout, 1);
        check("timeout_cycles", n, 16);
        tick(1);
        check("timeout_width", timeout, 0);
        serve(1, 8'h9A);
        toggle_req(0, 8'h13, 1'b0);
        serve(0, 8'h35);
        toggle_req(1, 8'h57, 1'b1);
        serve(1, 8'h9B);
        cli_lock[0] = 1'b0;
        to_seen = 0;
        issued  = 0;
`else
        to_seen = 0;
        issued  = 0;
        n       = 0;
        for (int k = 0; k < 1000; k++) begin
            tick(1);
            if (timeout !== 1'b0) to_seen++;
            if (spi_req !== spi_ack) issued++;
        end
        check("no_timeout", to_seen, 0);
        check("no_grant_while_locked", issued, 0);
        check("lock_owner0", owner, 0);
        cli_lock[0] = 1'b0;
        serve(1, 8'h9A);
`endif
        check("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_arbiter.md
Name: spi_arbiter

Overview:
- Parametrised N-client arbiter in front of the single chameleon2_spi master.
- Replaces the fixed two-way flash/mmc64 mux selected by rom_load_done, so flash loader, mmc64 and future SPI users (RTC, second card) can share the bus at run time.
- Round-robin grant using per-client toggle req/ack handshakes.
- Per-client lock input keeps ownership across multi-byte chip-select transactions.

Parameters:
- CLIENTS, 2, number of client ports (2..8).
- CLIENT_BITS, 1, width of owner index; must be >= clog2(CLIENTS).
- TIMEOUT_CYCLES, 100000, idle-with-lock cycles before forced release (used only with the optional feature).

Ports:
- clk  in  1  system clock (sysclk domain).
- reset  in  1  asynchronous, active-high reset.
- cli_req  in  CLIENTS  per-client request toggle; a transfer is pending when cli_req[i] != cli_ack[i].
- cli_ack  out  CLIENTS  per-client acknowledge toggle.
- cli_d  in  8*CLIENTS  per-client MOSI byte; client i occupies bits [8i+7:8i].
- cli_speed  in  CLIENTS  per-client SPI speed select.
- cli_lock  in  CLIENTS  client holds the bus between bytes (its CS asserted).
- cli_q  out  8  last received MISO byte; stable until the next completion.
- spi_req  out  1  request toggle to the SPI master.
- spi_ack  in  1  acknowledge toggle from the SPI master.
- spi_d  out  8  byte to transmit.
- spi_speed  out  1  speed for the current transfer.
- spi_q  in  8  byte received by the SPI master.
- owner  out  CLIENT_BITS  current or last granted client.
- owner_valid  out  1  owner currently holds the bus.
- timeout  out  1  one-cycle pulse on a forced lock release.

Behaviour:
- Reset values:
  - cli_ack=0, spi_req=0, spi_d=0, spi_speed=0, cli_q=0.
  - owner=CLIENTS-1, so client 0 wins first; owner_valid=0, timeout=0.
  - State=RESYNC.
- Clients must also reset cli_req to 0.
- RESYNC (1 cycle): spi_req<=spi_ack, which discards any stale mismatch from a reset taken mid-transfer; go to IDLE.
- IDLE, owner locked (owner_valid & cli_lock[owner]):
  - Only the owner may be served.
  - If pending[owner]: latch spi_d/spi_speed from that client and go to ISSUE.
  - Otherwise stay in IDLE. Other pending clients wait, no starvation guard unless the optional feature is compiled in.
- IDLE, not locked:
  - Scan from owner+1 with wrap-around (modulo CLIENTS) for the first pending client.
  - If one is found: owner<=that client, owner_valid<=1, latch its data, go to ISSUE.
  - If none is pending: owner_valid<=0; owner is kept as the round-robin pointer.
- ISSUE: spi_req<=~spi_req; go to WAIT.
- WAIT: when spi_ack==spi_req, on the same edge: cli_q<=spi_q and cli_ack[owner]<=~cli_ack[owner]; go to IDLE.
- Latency:
  - spi_req toggles 2 edges after the edge at which the pending mismatch is first sampled in IDLE.
  - cli_ack toggles on the edge where ack==req is first sampled in WAIT.
  - Minimum turnaround between back-to-back grants: 1 IDLE cycle.
- Lock semantics:
  - cli_lock is sampled only in IDLE and only for the current owner.
  - A non-owner's lock has no effect until that client is granted.
  - Releasing the lock lets round-robin resume from owner+1.
- Client rules: cli_d, cli_speed and cli_req are stable while that client is pending. A client toggling req twice before ack is illegal and its behaviour is undefined.
- Simultaneous pending clients: the round-robin order decides, with no fixed priority.
- Asynchronous reset in any state returns all outputs to their reset values immediately.

Optional Feature:
- Macro: SPI_ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter runs while in IDLE with the owner locked and no pending request from the owner.
  - The counter clears whenever the owner is served or unlocks.
  - At TIMEOUT_CYCLES: timeout pulses for 1 cycle and owner_valid<=0.
  - That client's lock is then masked until it deasserts cli_lock; round-robin resumes.
- Without the macro: no counter; timeout is tied to 0; a lock is held indefinitely.

Test Plan:
- Reset, then client 0 toggles req with d=0xA5, speed=1 -> spi_req toggles 2 edges later, spi_d=0xA5, spi_speed=1. Return spi_ack with spi_q=0x3C -> cli_ack[0] toggles and cli_q=0x3C.
- CLIENTS=3, all three toggle req on the same cycle -> grants in order 0,1,2. Then client 0 again -> granted after 2, confirming wrap-around.
- Client 1 holds cli_lock across 4 bytes while client 0 is pending -> all 4 bytes from client 1 go first. Client 0 is granted only after client 1 drops lock.
- Assert reset during WAIT with spi_ack != spi_req -> after RESYNC spi_req==spi_ack, no spurious cli_ack toggle, next request served normally.
- SPI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16: client 0 locked and idle while client 1 is pending -> timeout pulses after 16 cycles, client 1 is granted, and client 0's lock is ignored until it deasserts.
- Without SPI_ARB_TIMEOUT_EN, same stimulus for 1000 cycles -> timeout stays 0 and client 1 is never granted.
